// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - parametrised start/data/parity/stop serial frame receiver
// with a valid/ready holding register and overrun pulse.
module serial_frame_rx #(
  parameter int DATA_W      = 8,
  parameter int CLK_DIV     = 4,
  parameter int PARITY_MODE = 1,
  parameter int MSB_FIRST   = 1
) (
  input  logic                        iClock,
  input  logic                        iReset,
  input  logic                        iSerial,
  input  logic                        iReady,
  output logic [DATA_W-1:0]           oData,
  output logic [$clog2(DATA_W+1)-1:0] oOnes,
  output logic                        oParityErr,
  output logic                        oFrameErr,
  output logic                        oValid,
  output logic                        oOverrun,
  output logic                        oBusy
);
  localparam int OW = $clog2(DATA_W + 1);
  localparam int TW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_sync1;
  logic              r_s;
  logic              r_s_d;
  logic [TW-1:0]     r_timer;
  logic [IW-1:0]     r_bit_idx;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_next;
  logic [OW-1:0]     r_ones;
  logic              r_par_err;
  logic              w_timer_end;
  logic              w_mid;
  logic              w_fall;
  logic              w_data_sample;
  logic              w_par_sample;
  logic              w_complete;
  logic              w_par_exp;

  assign oBusy = (r_state != S_IDLE);

  always_comb begin
    w_state_next  = r_state;
    w_data_sample = 1'b0;
    w_par_sample  = 1'b0;
    w_complete    = 1'b0;
    w_timer_end   = (r_timer == TW'(CLK_DIV - 1));
    w_mid         = (r_timer == TW'(CLK_DIV / 2 - 1));
    w_fall        = r_s_d & ~r_s;
    case (r_state)
      S_IDLE:   if (w_fall) w_state_next = S_START;
      // A start bit that is high again at mid-bit is a glitch, not a frame.
      S_START:  if (w_mid) w_state_next = r_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (w_timer_end) begin
          w_data_sample = 1'b1;
          if (r_bit_idx == IW'(DATA_W - 1))
            w_state_next = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_timer_end) begin
          w_par_sample = 1'b1;
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_timer_end) begin
          w_complete   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_data_next = r_data;
    for (int i = 0; i < DATA_W; i++) begin
      if (i == ((MSB_FIRST != 0) ? (DATA_W - 1 - int'(r_bit_idx)) : int'(r_bit_idx)))
        w_data_next[i] = r_s;
    end
    w_par_exp = (PARITY_MODE == 2) ? ~(^r_data) : (^r_data);
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_sync1    <= 1'b1;
      r_s        <= 1'b1;
      r_s_d      <= 1'b1;
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_bit_idx  <= '0;
      r_data     <= '0;
      r_ones     <= '0;
      r_par_err  <= 1'b0;
      oData      <= '0;
      oOnes      <= '0;
      oParityErr <= 1'b0;
      oFrameErr  <= 1'b0;
      oValid     <= 1'b0;
      oOverrun   <= 1'b0;
    end else begin
      r_sync1 <= iSerial;
      r_s     <= r_sync1;
      r_s_d   <= r_s;
      r_state <= w_state_next;

      if (w_state_next != r_state || w_timer_end)
        r_timer <= '0;
      else if (r_state != S_IDLE)
        r_timer <= r_timer + TW'(1);

      if (r_state == S_START && w_state_next == S_DATA) begin
        r_bit_idx <= '0;
        r_data    <= '0;
        r_ones    <= '0;
        r_par_err <= 1'b0;
      end
      if (w_data_sample) begin
        r_data    <= w_data_next;
        r_ones    <= r_ones + OW'(r_s);
        r_bit_idx <= r_bit_idx + IW'(1);
      end
      if (w_par_sample)
        r_par_err <= (r_s != w_par_exp);

      // A consumer accepting in the completion cycle frees the slot for the new frame.
      oOverrun <= 1'b0;
      if (w_complete) begin
        if (!oValid || iReady) begin
          oData      <= r_data;
          oOnes      <= r_ones;
          oParityErr <= r_par_err;
          oFrameErr  <= ~r_s;
          oValid     <= 1'b1;
        end else begin
          oOverrun   <= 1'b1;
        end
      end else if (oValid && iReady) begin
        oValid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - self-checking bench for serial_frame_rx (default and
// 5-bit/odd/LSB-first/CLK_DIV=6 builds).
module tb_serial_frame_rx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  = 1'b1;
  logic       ser0 = 1'b1, ser1 = 1'b1, rdy0 = 1'b0, rdy1 = 1'b0;
  logic [7:0] d0;
  logic [3:0] ones0;
  logic       perr0, ferr0, val0, ovr0, busy0;
  logic [4:0] d1;
  logic [2:0] ones1;
  logic       perr1, ferr1, val1, ovr1, busy1;
  int         n_vec = 0, n_err = 0;

  // Stop-sample edge counted from the edge after which the start bit is driven:
  // 2 sync flops + edge detect, half a bit into START, then one bit per data/parity/stop.
  localparam int T0 = 3 + 4 / 2 + (8 + 1 + 1) * 4;

  serial_frame_rx #(.DATA_W(8), .CLK_DIV(4), .PARITY_MODE(1), .MSB_FIRST(1)) dut (
    .iClock(clk), .iReset(rst), .iSerial(ser0), .iReady(rdy0),
    .oData(d0), .oOnes(ones0), .oParityErr(perr0), .oFrameErr(ferr0),
    .oValid(val0), .oOverrun(ovr0), .oBusy(busy0));

  serial_frame_rx #(.DATA_W(5), .CLK_DIV(6), .PARITY_MODE(2), .MSB_FIRST(0)) dut6 (
    .iClock(clk), .iReset(rst), .iSerial(ser1), .iReady(rdy1),
    .oData(d1), .oOnes(ones1), .oParityErr(perr1), .oFrameErr(ferr1),
    .oValid(val1), .oOverrun(ovr1), .oBusy(busy1));

  function automatic logic [31:0] mk0(input logic [7:0] d, input logic p, input logic stop);
    logic [31:0] tx = '0;
    for (int i = 0; i < 8; i++) tx[1+i] = d[7-i];
    tx[9]  = p;
    tx[10] = stop;
    return tx;
  endfunction

  function automatic logic [31:0] mk1(input logic [4:0] d, input logic p, input logic stop);
    logic [31:0] tx = '0;
    for (int i = 0; i < 5; i++) tx[1+i] = d[i];
    tx[6] = p;
    tx[7] = stop;
    return tx;
  endfunction

  function automatic logic [14:0] exp0(input logic [7:0] d, input logic p, input logic stop);
    return {d, 4'($countones(d)), p != (^d), ~stop, 1'b1};
  endfunction

  function automatic logic [10:0] exp1(input logic [4:0] d, input logic p, input logic stop);
    return {d, 3'($countones(d)), p != ~(^d), ~stop, 1'b1};
  endfunction

  task automatic send(input int which, input logic [31:0] tx, input int len);
    for (int i = 0; i < len; i++) begin
      if (which == 0) ser0 = tx[i]; else ser1 = tx[i];
      repeat ((which == 0) ? 4 : 6) @(posedge clk);
      #1;
    end
    if (which == 0) ser0 = 1'b1; else ser1 = 1'b1;
  endtask

  task automatic wait_valid(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((which == 0) ? val0 : val1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic rx0(input logic [7:0] d, input logic p, input logic stop, input string nm);
    bit ok;
    logic [14:0] e;
    send(0, mk0(d, p, stop), 11);
    wait_valid(0, ok);
    e = exp0(d, p, stop);
    n_vec++;
    if (!ok || {d0, ones0, perr0, ferr0, val0} !== e) begin
      n_err++;
      $display("FAIL %s: got %h want %h (valid seen %0d)", nm, {d0, ones0, perr0, ferr0, val0}, e, ok);
    end
    rdy0 = 1'b1; @(posedge clk); #1; rdy0 = 1'b0;
    n_vec++;
    if (val0 !== 1'b0) begin
      n_err++;
      $display("FAIL %s_consume: valid %b want 0", nm, val0);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic rx1(input logic [4:0] d, input logic p, input logic stop, input string nm);
    bit ok;
    logic [10:0] e;
    send(1, mk1(d, p, stop), 8);
    wait_valid(1, ok);
    e = exp1(d, p, stop);
    n_vec++;
    if (!ok || {d1, ones1, perr1, ferr1, val1} !== e) begin
      n_err++;
      $display("FAIL %s: got %h want %h (valid seen %0d)", nm, {d1, ones1, perr1, ferr1, val1}, e, ok);
    end
    rdy1 = 1'b1; @(posedge clk); #1; rdy1 = 1'b0;
    n_vec++;
    if (val1 !== 1'b0) begin
      n_err++;
      $display("FAIL %s_consume: valid %b want 0", nm, val1);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({d0, ones0, perr0, ferr0, val0, ovr0, busy0} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_dut0: got %h want 0", {d0, ones0, perr0, ferr0, val0, ovr0, busy0});
    end
    n_vec++;
    if ({d1, ones1, perr1, ferr1, val1, ovr1, busy1} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_dut6: got %h want 0", {d1, ones1, perr1, ferr1, val1, ovr1, busy1});
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_basic_latency();
    fork
      send(0, mk0(8'hA5, 1'b0, 1'b1), 11);
      begin
        repeat (T0 - 1) @(posedge clk);
        #2;
        n_vec++;
        if (val0 !== 1'b0) begin
          n_err++;
          $display("FAIL latency_early: valid %b want 0", val0);
        end
        @(posedge clk); #2;
        n_vec++;
        if ({d0, ones0, perr0, ferr0, val0} !== exp0(8'hA5, 1'b0, 1'b1)) begin
          n_err++;
          $display("FAIL basic_a5: got %h want %h", {d0, ones0, perr0, ferr0, val0}, exp0(8'hA5, 1'b0, 1'b1));
        end
      end
    join
    rdy0 = 1'b1; @(posedge clk); #1; rdy0 = 1'b0;
    n_vec++;
    if (val0 !== 1'b0) begin
      n_err++;
      $display("FAIL basic_consume: valid %b want 0", val0);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_errors_and_glitch();
    bit saw_busy = 1'b0, saw_valid = 1'b0;
    rx0(8'hFF, 1'b1, 1'b1, "parity_err");
    rx0(8'h00, 1'b0, 1'b0, "frame_err");
    ser0 = 1'b0; @(posedge clk); #1; ser0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      saw_busy  |= busy0;
      saw_valid |= val0;
    end
    n_vec++;
    if ({saw_busy, busy0, saw_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL glitch: busy_seen/busy/valid_seen %b want 100", {saw_busy, busy0, saw_valid});
    end
  endtask

  task automatic test_overrun();
    bit ok;
    int n_ovr = 0;
    rdy0 = 1'b0;
    send(0, mk0(8'h3C, 1'b0, 1'b1), 11);
    wait_valid(0, ok);
    fork
      send(0, mk0(8'h81, 1'b0, 1'b1), 11);
      for (int i = 0; i < T0 + 8; i++) begin
        @(posedge clk); #1;
        n_ovr += int'(ovr0);
      end
    join
    n_vec++;
    if (n_ovr != 1) begin
      n_err++;
      $display("FAIL overrun_pulse: %0d cycles high want 1", n_ovr);
    end
    n_vec++;
    if (!ok || {d0, ones0, perr0, ferr0, val0} !== exp0(8'h3C, 1'b0, 1'b1)) begin
      n_err++;
      $display("FAIL overrun_hold: got %h want %h", {d0, ones0, perr0, ferr0, val0}, exp0(8'h3C, 1'b0, 1'b1));
    end
    rdy0 = 1'b1; @(posedge clk); #1; rdy0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(0, mk0(8'h3C, 1'b0, 1'b1), 11);
    wait_valid(0, ok);
    fork
      send(0, mk0(8'h81, 1'b0, 1'b1), 11);
      begin
        repeat (T0 - 1) @(posedge clk);
        #1; rdy0 = 1'b1;
        @(posedge clk);
        #1; rdy0 = 1'b0;
        n_vec++;
        if (!ok || {d0, ones0, perr0, ferr0, val0, ovr0} !== {exp0(8'h81, 1'b0, 1'b1), 1'b0}) begin
          n_err++;
          $display("FAIL consume_at_completion: got %h want %h", {d0, ones0, perr0, ferr0, val0, ovr0}, {exp0(8'h81, 1'b0, 1'b1), 1'b0});
        end
      end
    join
    rdy0 = 1'b1; @(posedge clk); #1; rdy0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    logic [7:0] d = 8'h5A;
    rdy0 = 1'b0;
    send(0, mk0(8'h3C, 1'b0, 1'b1), 11);
    wait_valid(0, ok);
    ser0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 7; i >= 4; i--) begin
      ser0 = d[i];
      repeat (4) @(posedge clk);
      #1;
    end
    ser0 = d[3];
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({ok, val0, busy0} !== 3'b111) begin
      n_err++;
      $display("FAIL pre_reset: held/valid/busy %b want 111", {ok, val0, busy0});
    end
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    n_vec++;
    if ({d0, ones0, perr0, ferr0, val0, ovr0, busy0} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_mid_frame: got %h want 0", {d0, ones0, perr0, ferr0, val0, ovr0, busy0});
    end
    ser0 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rx0(8'h5A, 1'b0, 1'b1, "after_reset_5a");
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [4:0] d5;
    logic       p, stop;
    for (int k = 0; k < 16; k++) begin
      d    = 8'($urandom);
      p    = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0);
      rx0(d, p, stop, "random_dut0");
    end
    for (int k = 0; k < 8; k++) begin
      d5   = 5'($urandom);
      p    = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0);
      rx1(d5, p, stop, "random_dut6");
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_latency();
    test_errors_and_glitch();
    test_overrun();
    test_reset_mid_frame();
    rx1(5'b01011, 1'b0, 1'b1, "alt_cfg_01011");
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
Parametrised serial frame receiver, successor to the fixed 11-bit keyboard-style deserialiser. Single clock domain; bit timing comes from an internal divider, not a derived clock. Recovers start / DATA_W data / optional parity / stop frames and delivers data, ones count and error flags through a valid/ready holding register. Sits between the asynchronous serial pin and the decode/display logic.

Parameters:
DATA_W, 8, data bits per frame (1..16)
CLK_DIV, 4, iClock cycles per bit; must be >= 4 and even
PARITY_MODE, 1, 0 none, 1 even, 2 odd
MSB_FIRST, 1, 1: first data bit received goes to oData[DATA_W-1]; 0: to oData[0]

Ports:
iClock  in  1  system clock, all logic on rising edge
iReset  in  1  reset iReset, synchronous, active-high
iSerial  in  1  asynchronous serial line, idle high
iReady  in  1  consumer accepts held frame when high with oValid
oData  out  DATA_W  received data bits
oOnes  out  $clog2(DATA_W+1)  count of 1s in data bits only (start/parity/stop excluded)
oParityErr  out  1  parity mismatch for held frame; 0 when PARITY_MODE=0
oFrameErr  out  1  stop bit sampled 0 for held frame
oValid  out  1  holding register full
oOverrun  out  1  one-cycle pulse: completed frame dropped
oBusy  out  1  FSM not in IDLE

Behaviour:
- Reset (checked every edge, overrides everything): FSM->IDLE, counters 0, all outputs 0, synchroniser flops set to 1. Reset mid-frame aborts the frame; nothing delivered.
- iSerial passes a 2-flop synchroniser (s); edge detection uses s and its 1-cycle-delayed copy.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: a falling edge on s (delayed copy 1, s 0) -> START, bit-timer cleared.
- START: at timer = CLK_DIV/2-1 (mid-bit), sample s. If s=1 (glitch) -> IDLE, no output and no flags. If s=0 -> DATA, timer cleared, bit index 0.
- DATA: sample s each time the timer reaches CLK_DIV-1, then clear the timer. Store the bit at the position set by MSB_FIRST and add it to the running ones count. After DATA_W samples -> PARITY if PARITY_MODE != 0, else -> STOP.
- PARITY: sample after CLK_DIV cycles. Expected bit = XOR(data) for even, ~XOR(data) for odd. Mismatch sets the pending parity error. -> STOP.
- STOP: sample after CLK_DIV cycles. s=0 sets the pending frame error. Frame completes at this sample. The FSM goes to IDLE the same cycle, so a new start edge is detectable from the next cycle.
- Completion: on the cycle after the stop sample, the result is loaded into oData/oOnes/oParityErr/oFrameErr and oValid is set, unless dropped (see overrun below). Frames with errors are still delivered.
- Handshake: oValid stays high until a cycle with oValid=1 and iReady=1. That cycle the held frame is consumed and oValid clears next cycle. Outputs are stable while oValid=1 and not consumed.
- Completion while oValid=1 and iReady=0: the new frame is discarded, the held frame is unchanged, and oOverrun pulses high for exactly 1 cycle.
- Completion coincident with consumption (oValid=1, iReady=1): the new frame is loaded, oValid stays 1, and there is no overrun.
- Ones count saturates never: it ranges 0..DATA_W in a width of $clog2(DATA_W+1).
- oBusy = (state != IDLE).
- End-to-end latency from the stop-bit mid-point sample to oValid is 1 cycle.

Test Plan:
1. Defaults (DATA_W=8, CLK_DIV=4, even parity, MSB_FIRST). Send 0xA5 as bits 1,0,1,0,0,1,0,1, parity 0, stop 1. Expect oData=0xA5, oOnes=4, oParityErr=0, oFrameErr=0, oValid=1 one cycle after the stop sample. iReady=1 -> oValid=0 next cycle.
2. Send 0xFF with parity bit 1 (wrong for even). Expect oData=0xFF, oOnes=8, oParityErr=1, oFrameErr=0.
3. Send 0x00, parity 0, stop bit 0. Expect oData=0x00, oOnes=0, oFrameErr=1. Then pull the line low for 1 cycle only: oBusy rises then falls by mid-start, no oValid.
4. Hold iReady=0 and send 0x3C then 0x81. Expect oData stays 0x3C, oOverrun pulses 1 cycle at 0x81 completion, oValid stays 1. Repeat with iReady=1 at the exact completion cycle: oData=0x81, no oOverrun.
5. Assert iReset during DATA bit 4 of frame 0x5A. Expect all outputs 0 the next cycle and oBusy=0. A following clean 0x5A frame is received correctly with oOnes=4.
6. Rebuild with DATA_W=5, PARITY_MODE=2, MSB_FIRST=0, CLK_DIV=6. Send bits 1,1,0,1,0 then odd parity 0, stop 1. Expect oData=5'b01011, oOnes=3, oParityErr=0.
